// File: rtl/adc_line_capture_if.sv
// Bus between the ADC reader, the line capture block and the waterfall writer.
// The slave modport is the capture block; the master modport is the ADC/writer side.
interface adc_line_capture_if #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int OUT_WIDTH    = 8
);
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample_data;
    logic [8:0]              rd_addr;
    logic [OUT_WIDTH-1:0]    rd_data;
    logic                    line_ready;
    logic                    line_ack;
    logic                    overrun;

    modport slave (
        input  sample_valid, sample_data, rd_addr, line_ack,
        output rd_data, line_ready, overrun
    );

    modport master (
        output sample_valid, sample_data, rd_addr, line_ack,
        input  rd_data, line_ready, overrun
    );
endinterface

// File: rtl/adc_line_capture.sv
// Block-averages the ADC sample stream and packs display lines into a ping-pong buffer.
// The downstream writer reads the completed half by column index, then acknowledges it.
//
//   state    | meaning
//   FILL     | decimated values are written into half fill_sel
//   WAIT_ACK | fill half complete, read half still owned downstream; values dropped
module adc_line_capture #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int OUT_WIDTH    = 8,
    parameter int LINE_LEN     = 320,
    parameter int DECIM_LOG2   = 2
) (
    input logic               clk,
    input logic               reset,
    adc_line_capture_if.slave bus
);
    localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int PTR_W = $clog2(LINE_LEN);
    localparam int DEPTH = 2 * LINE_LEN;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LINE_LEN - 1);

    localparam logic [0:0] FILL     = 1'b0;
    localparam logic [0:0] WAIT_ACK = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 sv_q, sv_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     dec_cnt_q, dec_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 fill_sel_q, fill_sel_d;
    logic                 line_ready_q, line_ready_d;
    logic                 overrun_q, overrun_d;
    logic [OUT_WIDTH-1:0] rd_data_q;

    logic                 accept;
    logic [ACC_W-1:0]     sum;
    logic                 dec_valid;
    logic [OUT_WIDTH-1:0] dec_val;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_in_range;

    logic [OUT_WIDTH-1:0] mem [0:DEPTH-1];

    // Edge detect and block averaging
    always_comb begin
        sv_d      = bus.sample_valid;
        accept    = bus.sample_valid & ~sv_q;
        sum       = acc_q + ACC_W'(bus.sample_data);
        dec_val   = sum[ACC_W-1 -: OUT_WIDTH];
        dec_valid = 1'b0;
        acc_d     = acc_q;
        dec_cnt_d = dec_cnt_q;
        if (accept) begin
            if (dec_cnt_q == LAST_CNT) begin
                dec_valid = 1'b1;
                acc_d     = '0;
                dec_cnt_d = '0;
            end else begin
                acc_d     = sum;
                dec_cnt_d = dec_cnt_q + CNT_W'(1);
            end
        end
    end

    // Line sequencing; the ack is folded into line_ready_d before completion is judged
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_sel_d   = fill_sel_q;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;
        line_ready_d = line_ready_q & ~bus.line_ack;
        case (state_q)
            FILL: begin
                if (dec_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        if (!line_ready_d) begin
                            fill_sel_d   = ~fill_sel_q;
                            line_ready_d = 1'b1;
                            wr_ptr_d     = '0;
                        end else begin
                            state_d = WAIT_ACK;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
            end
            WAIT_ACK: begin
                if (dec_valid) begin
                    overrun_d = 1'b1;
                end
                if (bus.line_ack) begin
                    fill_sel_d   = ~fill_sel_q;
                    line_ready_d = 1'b1;
                    wr_ptr_d     = '0;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        wr_idx = IDX_W'(wr_ptr_q);
        if (fill_sel_q) begin
            wr_idx = wr_idx + IDX_W'(LINE_LEN);
        end
        rd_in_range = (int'(bus.rd_addr) < LINE_LEN);
        rd_idx      = IDX_W'(bus.rd_addr);
        if (!fill_sel_q) begin
            rd_idx = rd_idx + IDX_W'(LINE_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            sv_q         <= 1'b0;
            acc_q        <= '0;
            dec_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            fill_sel_q   <= 1'b0;
            line_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sv_q         <= sv_d;
            acc_q        <= acc_d;
            dec_cnt_q    <= dec_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_sel_q   <= fill_sel_d;
            line_ready_q <= line_ready_d;
            overrun_q    <= overrun_d;
        end
    end

    // Buffer RAM is never cleared so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_in_range) begin
            rd_data_q <= mem[rd_idx];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.line_ready = line_ready_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: doc/adc_line_capture.md
Name: adc_line_capture

Overview:
- Sits between the SPI ADC reader and the waterfall RAM writer.
- Decimates the ADC sample stream by block-averaging, then packs one display line of LINE_LEN 8-bit values into a ping-pong line buffer.
- The waterfall writer reads a completed line by column index during its write phase, then acknowledges it. Capture then continues into the other half.

Parameters:
- SAMPLE_WIDTH, 12, ADC sample width.
- OUT_WIDTH, 8, stored pixel/sample width.
- LINE_LEN, 320, values per line (display width).
- DECIM_LOG2, 2, log2 of the number of ADC samples averaged per stored value.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  ADC ready; level signal, sample taken on its 0->1 transition.
- sample_data  in  SAMPLE_WIDTH  ADC result; valid while sample_valid high.
- rd_addr  in  9  column index into the completed line.
- rd_data  out  OUT_WIDTH  completed-line value; registered.
- line_ready  out  1  a completed line is available to read.
- line_ack  in  1  single-cycle pulse: downstream has finished with the line.
- overrun  out  1  sticky: at least one decimated value was dropped.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high, and is the only reset.
- Reset values:
  - rd_data=0, line_ready=0, overrun=0.
  - wr_ptr=0, acc=0, dec_cnt=0, fill_sel=0, state=FILL, edge-detect register=0.
  - Buffer RAM contents are not cleared. rd_data before the first line_ready is unspecified apart from its reset value.
- Edge detect:
  - A sample is accepted in the cycle where sample_valid=1 and its registered copy =0.
  - A held-high sample_valid yields exactly one sample.
- Decimation:
  - acc is SAMPLE_WIDTH+DECIM_LOG2 bits. On each accepted sample, acc+=sample_data and dec_cnt++.
  - When dec_cnt wraps at 2^DECIM_LOG2, the decimated value is (acc+sample)>>DECIM_LOG2, truncated to its top OUT_WIDTH bits (bits [11:4] at defaults).
  - On wrap, acc and dec_cnt clear in the same cycle. No overflow is possible.
  - DECIM_LOG2=0 passes samples straight through.
- State FILL:
  - Each decimated value is written to buffer half fill_sel at wr_ptr, and wr_ptr increments.
  - On the write with wr_ptr==LINE_LEN-1: if line_ready==0 (after this cycle's ack), then fill_sel toggles, line_ready<=1, wr_ptr<=0, and the state stays FILL. Otherwise go to WAIT_ACK.
- State WAIT_ACK:
  - The fill half is complete and the read half is still owned downstream.
  - Decimated values arriving here are dropped, and overrun<=1.
  - Averaging continues so the cadence is kept.
  - On line_ack: fill_sel toggles, line_ready stays 1, wr_ptr<=0, go to FILL.
- line_ack:
  - With line_ready=1, line_ready clears next cycle unless a swap occurs in the same cycle.
  - Ignored when line_ready=0.
  - Ack and line completion in the same cycle: the ack is processed first, so the swap happens and line_ready remains 1.
- Read port:
  - rd_data <= buffer[~fill_sel][rd_addr], 1-cycle latency.
  - rd_addr>=LINE_LEN returns 0.
  - Reads always target the half not being filled, so a read never sees a partial line.
- Buffer: 2*LINE_LEN x OUT_WIDTH, one write port and one read port (EBR inference).
- Reset mid-line: the partial line and the accumulator are discarded. The capture after reset starts at wr_ptr=0.
- Throughput: one accepted sample per cycle maximum. The ADC rate is far lower.

Test Plan:
- Constant input: sample_data=12'hABC for 1280 edges, DECIM_LOG2=2 -> line_ready rises after the 1280th edge. Reading addr 0..319 returns 8'hAB each, with 1-cycle latency. overrun=0.
- Averaging: samples 12'h000,12'h010,12'h020,12'h030 repeated -> each stored value equals (0x060>>2)=0x018 truncated -> 8'h01.
- Edge detect: sample_valid held high for 50 cycles with one rising edge -> exactly one sample accepted (dec_cnt=1). Four such pulses -> one stored value.
- Overrun: no ack after the first line, feed 2 more lines plus 4 samples -> state WAIT_ACK, overrun=1. After line_ack, the next line fills from wr_ptr=0 and the first line's data is still readable until the swap.
- Simultaneous: line_ack asserted in the same cycle as the final write of line 2 -> line_ready stays 1, the read half switches to line 2 data, overrun=0.
- Reset at wr_ptr=150 -> all outputs take their reset values next cycle. The next line_ready occurs only after a full 320x4 samples.
